sim_icache: RTL and testbench

- Small direct-mapped instruction cache between the core fetch port (icache cmd/rsp) and the simulation word memory (RAMHelper-style, 64-bit words).
- Replaces the direct RAM hookup on the instruction side.
- Hits return in 1 cycle, matching the current fetch timing.
- Misses refill a whole line through a request/response memory port with arbitrary latency.
- Fence.i-style flush input invalidates all lines.

---
 rtl/sim_icache.sv | 162 ++++++++++++++++
 tb/tb_sim_icache.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_icache.sv
// Direct-mapped instruction cache between the fetch port and the 64-bit simulation word memory.
// Define SIM_ICACHE_PERF_EN to add the perf_hits/perf_misses counter outputs.
module sim_icache #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        icache_cmd_valid,
  output logic        icache_cmd_ready,
  input  logic [63:0] icache_cmd_payload_addr,
  output logic        icache_rsp_valid,
  output logic [31:0] icache_rsp_payload_data,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [27:0] mem_req_idx,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data
`ifdef SIM_ICACHE_PERF_EN
  ,
  output logic [63:0] perf_hits,
  output logic [63:0] perf_misses
`endif
);

  localparam int unsigned SB = $clog2(SETS);
  localparam int unsigned LB = $clog2(LINE_WORDS);
  localparam int unsigned CW = (LB > 0) ? LB : 1;

  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_WAIT, RESPOND} state_e;

  state_e state_q, state_d;

  logic [28:0]   off_w;
  logic [27:0]   w, line, tag;
  logic [SB-1:0] set;
  logic [CW-1:0] wofs;
  logic [63:0]   hit_word, fill_word;
  logic          hit, accept, last, fill_done;

  logic [27:0]   tag_q [SETS];
  logic [SETS-1:0] valid_q;
  logic [63:0]   data_q [SETS][LINE_WORDS];

  logic [27:0]   line_q;
  logic [SB-1:0] set_q;
  logic [CW-1:0] wofs_q, cnt_q;
  logic          sel_q, flush_pend_q, rsp_hit_q;
  logic [31:0]   rsp_data_q;

  always_comb begin
    off_w    = 29'((icache_cmd_payload_addr - BASE_ADDR) >> 2);
    w        = off_w[28:1];
    line     = w >> LB;
    set      = line[SB-1:0];
    tag      = line >> SB;
    wofs     = CW'(w & 28'(LINE_WORDS - 1));
    hit      = valid_q[set] && (tag_q[set] == tag);
    hit_word = data_q[set][wofs];
    accept   = icache_cmd_valid && (state_q == IDLE);
    set_q    = line_q[SB-1:0];
    fill_word = data_q[set_q][wofs_q];
    last      = (cnt_q == CW'(LINE_WORDS - 1));
    fill_done = (state_q == REFILL_WAIT) && mem_rsp_valid && last;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (accept && !hit) state_d = REFILL_REQ;
      REFILL_REQ:  if (mem_req_ready) state_d = REFILL_WAIT;
      REFILL_WAIT: if (mem_rsp_valid) state_d = last ? RESPOND : REFILL_REQ;
      RESPOND:     state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    icache_cmd_ready        = 1'b0;
    icache_rsp_valid        = rsp_hit_q;
    icache_rsp_payload_data = rsp_data_q;
    mem_req_valid           = 1'b0;
    mem_req_idx             = '0;
    unique case (state_q)
      IDLE:       icache_cmd_ready = 1'b1;
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_idx   = (line_q << LB) | 28'(cnt_q);
      end
      RESPOND: begin
        icache_rsp_valid        = 1'b1;
        icache_rsp_payload_data = sel_q ? fill_word[63:32] : fill_word[31:0];
      end
      default: ;
    endcase
  end

  // A flush seen anywhere during the refill keeps the new line invalid; flush wins over the fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (fill_done && !flush_pend_q && !flush) valid_q[set_q] <= 1'b1;
      if (flush) valid_q <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_done) tag_q[set_q] <= line_q >> SB;
    if ((state_q == REFILL_WAIT) && mem_rsp_valid) data_q[set_q][cnt_q] <= mem_rsp_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      line_q       <= '0;
      wofs_q       <= '0;
      sel_q        <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      rsp_hit_q <= accept && hit;
      if (accept && hit) rsp_data_q <= off_w[0] ? hit_word[63:32] : hit_word[31:0];
      if (accept && !hit) begin
        line_q       <= line;
        wofs_q       <= wofs;
        sel_q        <= off_w[0];
        cnt_q        <= '0;
        flush_pend_q <= 1'b0;
      end else begin
        if (flush && ((state_q == REFILL_REQ) || (state_q == REFILL_WAIT))) flush_pend_q <= 1'b1;
        if ((state_q == REFILL_WAIT) && mem_rsp_valid && !last) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef SIM_ICACHE_PERF_EN
  logic [63:0] perf_hits_q, perf_misses_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else begin
      if (accept && hit)  perf_hits_q   <= perf_hits_q + 64'd1;
      if (accept && !hit) perf_misses_q <= perf_misses_q + 64'd1;
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_sim_icache.sv
// Randomized self-checking bench for sim_icache against a set/tag reference model and a latency-varying memory.
module tb_sim_icache;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int unsigned SETS = 64;
  localparam int unsigned LW   = 2;

  logic        clock, reset;
  logic        icache_cmd_valid, icache_cmd_ready;
  logic [63:0] icache_cmd_payload_addr;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_payload_data;
  logic        flush;
  logic        mem_req_valid, mem_req_ready;
  logic [27:0] mem_req_idx;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
`ifdef SIM_ICACHE_PERF_EN
  logic [63:0] perf_hits, perf_misses;
`endif

  sim_icache #(.BASE_ADDR(BASE), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clock(clock), .reset(reset),
    .icache_cmd_valid(icache_cmd_valid), .icache_cmd_ready(icache_cmd_ready),
    .icache_cmd_payload_addr(icache_cmd_payload_addr),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_payload_data(icache_rsp_payload_data),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_idx(mem_req_idx),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef SIM_ICACHE_PERF_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned total = 0, bad = 0;
  int unsigned salt;
  int unsigned force_lat = 0;
  bit          mem_busy = 0;
  int unsigned req_log[$];
  bit          model_v[SETS];
  int unsigned model_tag[SETS];
  longint unsigned exp_hits = 0, exp_misses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] memword(input int unsigned idx);
    logic [31:0] hi, lo;
    if (idx == 0) return 64'h00000413_00000093;
    hi = 32'(idx * 32'h9E37_79B1 + salt);
    lo = 32'((~idx) * 32'h85EB_CA77 ^ salt);
    return {hi, lo};
  endfunction

  // Memory: random ready, 1..4 cycle (or forced) response latency, one request at a time.
  initial begin
    int unsigned cd, pend_idx;
    cd = 0; pend_idx = 0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    forever begin
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      if (mem_busy) begin
        if (cd == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = memword(pend_idx);
          mem_busy      = 0;
        end else cd--;
      end
      mem_req_ready = !mem_busy && ($urandom_range(0, 3) != 0);
      if (mem_req_valid === 1'b1 && mem_req_ready) begin
        pend_idx = 32'(mem_req_idx);
        req_log.push_back(pend_idx);
        cd = (force_lat != 0) ? force_lat : $urandom_range(0, 3);
        mem_busy = 1;
      end
    end
  end

  task automatic model_clear();
    for (int unsigned s = 0; s < SETS; s++) model_v[s] = 0;
  endtask

  task automatic wait_ready();
    int unsigned k;
    k = 0;
    while (!icache_cmd_ready && k < 50) begin @(negedge clock); k++; end
    check("ready", icache_cmd_ready, 1'b1);
  endtask

  task automatic flush_idle();
    wait_ready();
    flush = 1'b1;
    model_clear();
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a, input bit fl_acc, input bit fl_ref);
    logic [63:0] off, word;
    logic [31:0] exp;
    int unsigned w, line, set, tag, n0, k;
    bit sel, hit, seen, flushed;
    off  = a - BASE;
    w    = 32'(off[30:3]);
    sel  = off[2];
    line = w / LW;
    set  = line % SETS;
    tag  = line / SETS;
    word = memword(w);
    exp  = sel ? word[63:32] : word[31:0];
    wait_ready();
    hit = model_v[set] && (model_tag[set] == tag);
    icache_cmd_valid = 1'b1;
    icache_cmd_payload_addr = a;
    flush = fl_acc;
    if (fl_acc) model_clear();
    if (hit) exp_hits++; else exp_misses++;
    n0 = req_log.size();
    @(negedge clock);
    icache_cmd_valid = 1'b0;
    flush = 1'b0;
    if (hit) begin
      check("hit_rsp_valid", icache_rsp_valid, 1'b1);
      check("hit_data", icache_rsp_payload_data, exp);
      check("hit_no_req", req_log.size(), n0);
    end else begin
      check("miss_first_cycle", icache_rsp_valid, 1'b0);
      seen = 0; flushed = 0; k = 0;
      while (k < 200) begin
        flush = 1'b0;
        if (icache_rsp_valid) begin seen = 1; break; end
        if (fl_ref && !flushed && mem_busy) begin
          flush = 1'b1; flushed = 1; model_clear();
        end
        @(negedge clock);
        k++;
      end
      flush = 1'b0;
      check("miss_rsp_seen", seen, 1'b1);
      if (seen) check("miss_data", icache_rsp_payload_data, exp);
      check("miss_req_cnt", req_log.size(), n0 + LW);
      for (int unsigned i = 0; i < LW; i++)
        if (req_log.size() > n0 + i) check("miss_idx", req_log[n0 + i], line * LW + i);
      @(negedge clock);
      check("rsp_one_pulse", icache_rsp_valid, 1'b0);
      model_v[set] = !flushed;
      model_tag[set] = tag;
    end
  endtask

  initial begin
    int unsigned n0, k;
    bit got;
    logic [63:0] a;
    salt = $urandom;
    reset = 1'b1; flush = 1'b0;
    icache_cmd_valid = 1'b0; icache_cmd_payload_addr = '0;
    model_clear();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_ready", icache_cmd_ready, 1'b1);
    check("rst_rsp_valid", icache_rsp_valid, 1'b0);
    check("rst_rsp_data", icache_rsp_payload_data, 32'h0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_idx", mem_req_idx, 28'h0);

    // First miss on word 0, then hit on the other half
    fetch(BASE, 0, 0);
    fetch(BASE + 64'h4, 0, 0);

    // Flush in idle forces a refill; then sequential run with latency 3
    flush_idle();
    force_lat = 2;
    n0 = req_log.size();
    for (int unsigned i = 0; i < 8; i++) fetch(BASE + 64'(i * 4), 0, 0);
    check("seq_refill_words", req_log.size() - n0, 4);
    force_lat = 0;

    // Conflict in set 0
    flush_idle();
    n0 = req_log.size();
    fetch(BASE, 0, 0);
    fetch(BASE + 64'h400, 0, 0);
    fetch(BASE, 0, 0);
    check("conflict_refill_words", req_log.size() - n0, 3 * LW);

    // Flush during refill: response delivered, line left invalid
    flush_idle();
    fetch(BASE + 64'h8, 0, 1);
    n0 = req_log.size();
    fetch(BASE + 64'h8, 0, 0);
    check("flush_refill_remiss", req_log.size() - n0, LW);

    // Reset in REFILL_WAIT with a late memory response
    flush_idle();
    force_lat = 8;
    wait_ready();
    icache_cmd_valid = 1'b1;
    icache_cmd_payload_addr = BASE + 64'h40;
    @(negedge clock);
    icache_cmd_valid = 1'b0;
    k = 0;
    while (!mem_busy && k < 50) begin @(negedge clock); k++; end
    check("rst_mid_req_seen", mem_busy, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_ready", icache_cmd_ready, 1'b1);
    got = 0;
    repeat (12) begin @(negedge clock); if (icache_rsp_valid) got = 1; end
    check("rst_mid_no_rsp", got, 1'b0);
    check("rst_mid_stale_done", mem_busy, 1'b0);
    model_clear();
    exp_hits = 0; exp_misses = 0;
    force_lat = 0;
    n0 = req_log.size();
    fetch(BASE + 64'h40, 0, 0);
    check("rst_mid_refetch_miss", req_log.size() - n0, LW);

    // Randomized traffic: mostly a small hot region, some conflicting far addresses
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) a = BASE + 64'($urandom_range(0, 255) * 4);
      else                           a = BASE + 64'($urandom_range(0, 16383) * 4);
      fetch(a, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end

`ifdef SIM_ICACHE_PERF_EN
    check("perf_hits", perf_hits, exp_hits);
    check("perf_misses", perf_misses, exp_misses);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
